// File: rtl/misr_pkg.sv
// Shared constants and state encoding for the result-side MISR checker.
// Optional feature macro used by the checker: MISR_TIMEOUT_EN.
package misr_pkg;

  localparam int          COUNT_W  = 16;
  localparam logic [31:0] DEF_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] DEF_SEED = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/misr_step.sv
// Combinational MISR step: shift left, fold the feedback polynomial
// when the outgoing bit is set, then absorb the result word.
module misr_step
  import misr_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = DEF_POLY
) (
  input  logic [WIDTH-1:0] sig,
  input  logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] sig_next
);

  assign sig_next = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ res;

endmodule

// File: rtl/res_misr32.sv
// Compacts result beats into a MISR signature and compares it with a golden value.
// Optional idle-timeout abort is built only when MISR_TIMEOUT_EN is defined.
//
// state   | meaning
// ST_IDLE | waiting for start, signature held
// ST_RUN  | accepting res_valid beats until N_PATTERNS are absorbed
// ST_DONE | run finished, signature frozen, pass reported until next start
module res_misr32
  import misr_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] POLY       = DEF_POLY,
  parameter logic [WIDTH-1:0] SEED       = DEF_SEED,
  parameter int               N_PATTERNS = 16,
  parameter int               TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               res_valid,
  input  logic [WIDTH-1:0]   res,
  input  logic [WIDTH-1:0]   expected,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [WIDTH-1:0]   signature,
  output logic [COUNT_W-1:0] count
`ifdef MISR_TIMEOUT_EN
  ,
  output logic               timeout
`endif
);

  localparam logic [COUNT_W-1:0] N_LAST = COUNT_W'(N_PATTERNS);

  if (N_PATTERNS < 1 || N_PATTERNS > 65535) begin : g_bad_npat
    $error("res_misr32: N_PATTERNS out of range 1..65535");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_tmo
    $error("res_misr32: TIMEOUT out of range 1..65535");
  end

  state_t             state, state_next;
  logic [WIDTH-1:0]   sig_next, step_sig;
  logic [COUNT_W-1:0] count_next;
  logic               sig_match;

  misr_step #(.WIDTH(WIDTH), .POLY(POLY)) u_step (
    .sig      (signature),
    .res      (res),
    .sig_next (step_sig)
  );

`ifdef MISR_TIMEOUT_EN
  localparam logic [COUNT_W-1:0] TMO_LOAD = COUNT_W'(TIMEOUT);

  logic [COUNT_W-1:0] idle_cnt, idle_next;
  logic               timeout_next;

  // Idle timer counts down from TIMEOUT; reload on start and on every accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      idle_cnt <= idle_next;
      timeout  <= timeout_next;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      signature <= SEED;
      count     <= '0;
    end else begin
      state     <= state_next;
      signature <= sig_next;
      count     <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    sig_next   = signature;
    count_next = count;
`ifdef MISR_TIMEOUT_EN
    idle_next    = idle_cnt;
    timeout_next = timeout;
`endif
    case (state)
      ST_IDLE, ST_DONE: begin
        // a start in the same cycle as res_valid drops the beat
        if (start) begin
          state_next = ST_RUN;
          sig_next   = SEED;
          count_next = '0;
`ifdef MISR_TIMEOUT_EN
          idle_next    = TMO_LOAD;
          timeout_next = 1'b0;
`endif
        end
      end
      ST_RUN: begin
        if (res_valid) begin
          sig_next   = step_sig;
          count_next = count + COUNT_W'(1);
          if (count_next == N_LAST) state_next = ST_DONE;
`ifdef MISR_TIMEOUT_EN
          idle_next = TMO_LOAD;
        end else if (idle_cnt <= COUNT_W'(1)) begin
          state_next   = ST_DONE;
          timeout_next = 1'b1;
        end else begin
          idle_next = idle_cnt - COUNT_W'(1);
`endif
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign sig_match = (signature == expected);

`ifdef MISR_TIMEOUT_EN
  assign pass = done && sig_match && !timeout;
`else
  assign pass = done && sig_match;
`endif

endmodule

// File: tb/tb_res_misr32.sv
// Directed bench for res_misr32 with hand-computed signatures on several instances.
// Timeout checks are compiled only when MISR_TIMEOUT_EN is defined.
module tb_res_misr32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst_c;
  int   n_chk  = 0;
  int   n_fail = 0;

  // instance a: SEED=0, N=2
  logic start_a = 0, rv_a = 0, busy_a, done_a, pass_a;
  logic [31:0] res_a = '0, exp_a = '0, sig_a;
  logic [15:0] cnt_a;
  // instance b: SEED=0x8000_0000, N=1
  logic start_b = 0, rv_b = 0, busy_b, done_b, pass_b;
  logic [31:0] res_b = '0, exp_b = '0, sig_b;
  logic [15:0] cnt_b;
  // instance c: default SEED, N=4, own reset
  logic start_c = 0, rv_c = 0, busy_c, done_c, pass_c;
  logic [31:0] res_c = '0, exp_c = '0, sig_c;
  logic [15:0] cnt_c;
`ifdef MISR_TIMEOUT_EN
  logic start_t = 0, rv_t = 0, busy_t, done_t, pass_t, to_t, to_a, to_b, to_c;
  logic [31:0] res_t = '0, exp_t = '0, sig_t;
  logic [15:0] cnt_t;
`endif

  res_misr32 #(.SEED(32'h0), .N_PATTERNS(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .res_valid(rv_a), .res(res_a),
    .expected(exp_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .signature(sig_a), .count(cnt_a)
`ifdef MISR_TIMEOUT_EN
    , .timeout(to_a)
`endif
  );

  res_misr32 #(.SEED(32'h8000_0000), .N_PATTERNS(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .res_valid(rv_b), .res(res_b),
    .expected(exp_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .signature(sig_b), .count(cnt_b)
`ifdef MISR_TIMEOUT_EN
    , .timeout(to_b)
`endif
  );

  res_misr32 #(.N_PATTERNS(4)) dut_c (
    .clk(clk), .rst(rst_c), .start(start_c), .res_valid(rv_c), .res(res_c),
    .expected(exp_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .signature(sig_c), .count(cnt_c)
`ifdef MISR_TIMEOUT_EN
    , .timeout(to_c)
`endif
  );

`ifdef MISR_TIMEOUT_EN
  res_misr32 #(.N_PATTERNS(4), .TIMEOUT(5)) dut_t (
    .clk(clk), .rst(rst), .start(start_t), .res_valid(rv_t), .res(res_t),
    .expected(exp_t), .busy(busy_t), .done(done_t), .pass(pass_t),
    .signature(sig_t), .count(cnt_t), .timeout(to_t)
  );
`endif

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // default SEED 0xFFFF_FFFF with these beats gives 04C11DB6, 1, 3, 7
  logic [31:0] beats_c [4] = '{32'hFFFF_FFFF, 32'h0982_3B6D, 32'h0000_0001, 32'h0000_0001};
  logic [31:0] sigs_c  [4] = '{32'h04C1_1DB6, 32'h0000_0001, 32'h0000_0003, 32'h0000_0007};

  initial begin
    rst   = 1'b1;
    rst_c = 1'b1;
    tick;
    tick;
    chk_eq("rst_sig_c",  sig_c,  32'hFFFF_FFFF);
    chk_eq("rst_sig_a",  sig_a,  32'h0);
    chk_eq("rst_cnt_c",  cnt_c,  0);
    chk_eq("rst_busy_c", busy_c, 0);
    chk_eq("rst_done_c", done_c, 0);
    chk_eq("rst_pass_c", pass_c, 0);
    rst   = 1'b0;
    rst_c = 1'b0;

    // a: two beats, then pass depends on expected
    start_a = 1; tick; start_a = 0;
    chk_eq("a_busy", busy_a, 1);
    rv_a = 1; res_a = 32'h0000_00FF; tick;
    chk_eq("a_sig1", sig_a, 32'h0000_00FF);
    chk_eq("a_cnt1", cnt_a, 1);
    res_a = 32'h0; tick;
    rv_a = 0;
    chk_eq("a_sig2", sig_a, 32'h0000_01FE);
    chk_eq("a_done", done_a, 1);
    chk_eq("a_busy_off", busy_a, 0);
    exp_a = 32'h1FE; #1;
    chk_eq("a_pass_hi", pass_a, 1);
    exp_a = 32'h1FF; #1;
    chk_eq("a_pass_lo", pass_a, 0);
    rv_a = 1; res_a = 32'h1234_5678; tick; rv_a = 0;
    chk_eq("a_done_hold_sig", sig_a, 32'h0000_01FE);
    chk_eq("a_done_hold_cnt", cnt_a, 2);

    // b: feedback tap
    start_b = 1; tick; start_b = 0;
    rv_b = 1; res_b = 32'h0; tick; rv_b = 0;
    chk_eq("b_sig_poly", sig_b, 32'h04C1_1DB7);
    chk_eq("b_done", done_b, 1);
    exp_b = 32'h04C1_1DB7; #1;
    chk_eq("b_pass", pass_b, 1);

    // c: res_valid in IDLE ignored
    rv_c = 1; res_c = 32'hDEAD_BEEF; tick; rv_c = 0;
    chk_eq("c_idle_sig", sig_c, 32'hFFFF_FFFF);
    chk_eq("c_idle_cnt", cnt_c, 0);
    start_c = 1; tick; start_c = 0;
    chk_eq("c_cnt0", cnt_c, 0);
    chk_eq("c_busy0", busy_c, 1);
    // beats on even cycles, garbage and a stray start on odd cycles
    for (int i = 0; i < 7; i++) begin
      rv_c    = (i % 2 == 0);
      res_c   = rv_c ? beats_c[i/2] : 32'hA5A5_A5A5;
      start_c = (i == 3);
      tick;
      chk_eq($sformatf("c_cnt_%0d", i),  cnt_c,  (i / 2) + 1);
      chk_eq($sformatf("c_sig_%0d", i),  sig_c,  sigs_c[i/2]);
      chk_eq($sformatf("c_busy_%0d", i), busy_c, (i < 6) ? 1 : 0);
    end
    rv_c = 0; start_c = 0;
    chk_eq("c_done", done_c, 1);
    exp_c = 32'h7; #1;
    chk_eq("c_pass", pass_c, 1);

    // start + res_valid in DONE: reload wins
    start_c = 1; rv_c = 1; res_c = 32'h0000_1234; tick;
    start_c = 0; rv_c = 0;
    chk_eq("c_restart_sig",  sig_c,  32'hFFFF_FFFF);
    chk_eq("c_restart_cnt",  cnt_c,  0);
    chk_eq("c_restart_busy", busy_c, 1);
    chk_eq("c_restart_pass", pass_c, 0);

    // async reset after two beats
    for (int i = 0; i < 2; i++) begin
      rv_c = 1; res_c = beats_c[i]; tick;
    end
    rv_c = 0;
    chk_eq("c_pre_rst_sig", sig_c, 32'h0000_0001);
    rst_c = 1; #1;
    chk_eq("c_arst_sig",  sig_c,  32'hFFFF_FFFF);
    chk_eq("c_arst_cnt",  cnt_c,  0);
    chk_eq("c_arst_busy", busy_c, 0);
    chk_eq("c_arst_done", done_c, 0);
    #1 rst_c = 0;
    tick;
    chk_eq("c_post_rst_busy", busy_c, 0);
    start_c = 1; tick; start_c = 0;
    for (int i = 0; i < 4; i++) begin
      rv_c = 1; res_c = beats_c[i]; tick;
    end
    rv_c = 0;
    chk_eq("c_clean_sig",  sig_c,  32'h0000_0007);
    chk_eq("c_clean_done", done_c, 1);
    chk_eq("c_clean_pass", pass_c, 1);

`ifdef MISR_TIMEOUT_EN
    exp_t = 32'hFFFF_FFFF;
    start_t = 1; tick; start_t = 0;
    chk_eq("t_busy", busy_t, 1);
    repeat (4) tick;
    chk_eq("t_not_yet", done_t, 0);
    tick;
    chk_eq("t_done",    done_t, 1);
    chk_eq("t_timeout", to_t,   1);
    chk_eq("t_pass",    pass_t, 0);
    start_t = 1; tick; start_t = 0;
    chk_eq("t_clear", to_t, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
